// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the instruction/data memory arbiter
package mem_arb_pkg;

    // The latched request is sized to the processor word.
    localparam int ARB_WORD_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } ArbState;

    typedef enum logic {
        OWN_DATA,
        OWN_INSTR
    } ArbOwner;

    typedef struct packed {
        ArbOwner                owner;
        logic                   we;
        logic [ARB_WORD_W-1:0]  addr;
        logic [ARB_WORD_W-1:0]  wdata;
    } ArbReq;

endpackage

// File: rtl/arb_grant_picker.sv
// rtl/arb_grant_picker.sv - data-priority grant decision with a fetch anti-starvation streak limit
module arb_grant_picker
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic arbitrate_i,
    input  logic data_req_i,
    input  logic instr_req_i,
    output logic grant_valid_o,
    output logic owner_instr_o
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                streak_limit;
    logic                data_wins;

    assign streak_limit  = (streak_q == STREAK_W'(MAX_DATA_STREAK));
    assign data_wins     = data_req_i && !(streak_limit && instr_req_i);
    assign grant_valid_o = data_req_i || instr_req_i;
    assign owner_instr_o = !data_wins;

    // The streak only counts data grants that actually made a fetch wait.
    always_comb begin
        streak_d = streak_q;
        if (arbitrate_i && grant_valid_o) begin
            if (data_wins && instr_req_i) begin
                if (!streak_limit) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency single-port memory between fetch and data ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE       = 16,
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    input  logic                 InstrReq,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrValid,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWData,
    output logic                 MemEn,
    output logic                 MemWe,
    input  logic [WORD_SIZE-1:0] MemRData
);

    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);

    if (WORD_SIZE != ARB_WORD_W) begin : g_bad_word
        $error("mem_arbiter: WORD_SIZE must equal ARB_WORD_W");
    end
    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be at least 1");
    end
    if (MAX_DATA_STREAK < 1) begin : g_bad_streak
        $error("mem_arbiter: MAX_DATA_STREAK must be at least 1");
    end

    ArbState               state_q, state_d;
    ArbReq                 req_q, req_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0]  data_in_q, data_in_d;
    logic [WORD_SIZE-1:0]  instr_in_q, instr_in_d;

    logic                  arbitrate;
    logic                  grant_valid;
    logic                  owner_instr;
    ArbOwner               grant_owner;
    logic                  wait_last;

    assign arbitrate   = (state_q == ARB_IDLE);
    assign grant_owner = owner_instr ? OWN_INSTR : OWN_DATA;
    assign wait_last   = (wait_q == WAIT_W'(1));

    arb_grant_picker #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_picker (
        .clk_i         (Clock),
        .rst_ni        (Resetn),
        .arbitrate_i   (arbitrate),
        .data_req_i    (ReadData || WriteData),
        .instr_req_i   (InstrReq),
        .grant_valid_o (grant_valid),
        .owner_instr_o (owner_instr)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (grant_valid) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (wait_last) state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Done pulses come straight from the state register so they can never outlive DONE.
    always_comb begin
        DataDone   = 1'b0;
        InstrValid = 1'b0;
        if (state_q == ARB_DONE) begin
            DataDone   = (req_q.owner == OWN_DATA);
            InstrValid = (req_q.owner == OWN_INSTR);
        end
    end

    // A simultaneous read+write is carried out as a write only.
    always_comb begin
        req_d      = req_q;
        wait_d     = wait_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        data_in_d  = data_in_q;
        instr_in_d = instr_in_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    req_d.owner = grant_owner;
                    req_d.we    = (grant_owner == OWN_DATA) && WriteData;
                    req_d.addr  = (grant_owner == OWN_DATA) ? DataAddr : InstrAddr;
                    req_d.wdata = (grant_owner == OWN_DATA) ? DataOut : req_q.wdata;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (grant_owner == OWN_DATA) && WriteData;
                end
            end
            ARB_ISSUE: begin
                wait_d = WAIT_W'(MEM_LATENCY);
            end
            ARB_WAIT: begin
                wait_d = wait_q - WAIT_W'(1);
                if (wait_last && !req_q.we) begin
                    if (req_q.owner == OWN_DATA) begin
                        data_in_d = MemRData;
                    end else begin
                        instr_in_d = MemRData;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            req_q      <= '0;
            wait_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            data_in_q  <= '0;
            instr_in_q <= '0;
        end else begin
            req_q      <= req_d;
            wait_q     <= wait_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            data_in_q  <= data_in_d;
            instr_in_q <= instr_in_d;
        end
    end

    assign MemAddr  = req_q.addr;
    assign MemWData = req_q.wdata;
    assign MemEn    = mem_en_q;
    assign MemWe    = mem_we_q;
    assign DataIn   = data_in_q;
    assign InstrIn  = instr_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a 2-cycle memory model
module tb_mem_arbiter;

    logic        Clock;
    logic        Resetn;
    logic [15:0] DataAddr;
    logic [15:0] DataOut;
    logic        ReadData;
    logic        WriteData;
    logic [15:0] DataIn;
    logic        DataDone;
    logic [15:0] InstrAddr;
    logic        InstrReq;
    logic [15:0] InstrIn;
    logic        InstrValid;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic        MemEn;
    logic        MemWe;
    logic [15:0] MemRData;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .WORD_SIZE       (16),
        .MEM_LATENCY     (2),
        .MAX_DATA_STREAK (4)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .DataAddr   (DataAddr),
        .DataOut    (DataOut),
        .ReadData   (ReadData),
        .WriteData  (WriteData),
        .DataIn     (DataIn),
        .DataDone   (DataDone),
        .InstrAddr  (InstrAddr),
        .InstrReq   (InstrReq),
        .InstrIn    (InstrIn),
        .InstrValid (InstrValid),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemEn      (MemEn),
        .MemWe      (MemWe),
        .MemRData   (MemRData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory model: written words override a fixed preload; read data is valid only
    // in the single cycle MEM_LATENCY after the MemEn cycle, poison otherwise.
    logic        mem_clr;
    logic [15:0] mem [0:255];
    logic [255:0] written;
    logic [15:0] p0, p1;

    function automatic logic [15:0] preload(input logic [7:0] a);
        if (a == 8'h10) return 16'h00AB;
        if (a == 8'h30) return 16'h5A5A;
        return 16'h0000;
    endfunction

    always @(posedge Clock) begin
        if (mem_clr) begin
            written <= '0;
            p0      <= 16'hDEAD;
            p1      <= 16'hDEAD;
        end else begin
            if (MemEn && MemWe) begin
                mem[MemAddr[7:0]]     <= MemWData;
                written[MemAddr[7:0]] <= 1'b1;
            end
            if (MemEn && !MemWe) begin
                p0 <= written[MemAddr[7:0]] ? mem[MemAddr[7:0]] : preload(MemAddr[7:0]);
            end else begin
                p0 <= 16'hDEAD;
            end
            p1 <= p0;
        end
    end
    assign MemRData = p1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int          n_en;
    int          n_iv;
    int          n_pulse;
    int          n_dd;
    logic [15:0] seq;

    initial begin
        Resetn    = 1'b0;
        mem_clr   = 1'b1;
        DataAddr  = '0;
        DataOut   = '0;
        ReadData  = 1'b0;
        WriteData = 1'b0;
        InstrAddr = '0;
        InstrReq  = 1'b0;
        step(3);
        chk("rst_datain",   DataIn,           16'h0000);
        chk("rst_instrin",  InstrIn,          16'h0000);
        chk("rst_memaddr",  MemAddr,          16'h0000);
        chk("rst_memwdata", MemWData,         16'h0000);
        chk("rst_ctl",      {12'h0, DataDone, InstrValid, MemEn, MemWe}, 16'h0000);
        mem_clr = 1'b0;
        Resetn  = 1'b1;
        step(1);

        // Data read: issue at +1, done at +4
        ReadData = 1'b1;
        DataAddr = 16'h0010;
        step(1);
        chk("t1_memen",   {15'h0, MemEn}, 16'h0001);
        chk("t1_memwe",   {15'h0, MemWe}, 16'h0000);
        chk("t1_memaddr", MemAddr,        16'h0010);
        step(1);
        chk("t1_early_done", {15'h0, DataDone}, 16'h0000);
        chk("t1_wait_memen", {15'h0, MemEn},    16'h0000);
        step(2);
        chk("t1_done",    {15'h0, DataDone}, 16'h0001);
        chk("t1_datain",  DataIn,            16'h00AB);
        chk("t1_instrin", InstrIn,           16'h0000);
        ReadData = 1'b0;
        step(1);
        chk("t1_done_once", {15'h0, DataDone}, 16'h0000);

        // Data write then readback
        WriteData = 1'b1;
        DataAddr  = 16'h0020;
        DataOut   = 16'h1234;
        step(1);
        chk("t2_memen_we", {14'h0, MemEn, MemWe}, 16'h0003);
        chk("t2_memaddr",  MemAddr,               16'h0020);
        chk("t2_memwdata", MemWData,              16'h1234);
        step(3);
        chk("t2_done",        {15'h0, DataDone}, 16'h0001);
        chk("t2_datain_hold", DataIn,            16'h00AB);
        WriteData = 1'b0;
        step(1);
        ReadData = 1'b1;
        step(4);
        chk("t2_rb_done", {15'h0, DataDone}, 16'h0001);
        chk("t2_rb_data", DataIn,            16'h1234);
        ReadData = 1'b0;
        step(1);

        // Read and write together behave as a write
        ReadData  = 1'b1;
        WriteData = 1'b1;
        DataAddr  = 16'h0022;
        DataOut   = 16'hBEEF;
        step(1);
        chk("t6_memen_we", {14'h0, MemEn, MemWe}, 16'h0003);
        step(3);
        chk("t6_done",        {15'h0, DataDone}, 16'h0001);
        chk("t6_datain_hold", DataIn,            16'h1234);
        ReadData  = 1'b0;
        WriteData = 1'b0;
        step(1);
        ReadData = 1'b1;
        step(4);
        chk("t6_rb_data", DataIn, 16'hBEEF);
        ReadData = 1'b0;
        step(1);

        // Fetch held through its done pulse, dropped just after: one memory command only
        InstrReq  = 1'b1;
        InstrAddr = 16'h0030;
        n_en = 0;
        n_iv = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (MemEn) n_en++;
            if (InstrValid) n_iv++;
        end
        chk("t4_valid",   {15'h0, InstrValid}, 16'h0001);
        chk("t4_instrin", InstrIn,             16'h5A5A);
        @(posedge Clock);
        #1 InstrReq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (MemEn) n_en++;
            if (InstrValid) n_iv++;
        end
        chk("t4_memen_count", 16'(n_en), 16'd1);
        chk("t4_valid_count", 16'(n_iv), 16'd1);

        // Continuous data + fetch: four data grants, one fetch, then data again
        ReadData  = 1'b1;
        DataAddr  = 16'h0010;
        InstrReq  = 1'b1;
        InstrAddr = 16'h0030;
        seq     = '0;
        n_pulse = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (DataDone) begin
                seq = {seq[14:0], 1'b0};
                n_pulse++;
            end
            if (InstrValid) begin
                seq = {seq[14:0], 1'b1};
                n_pulse++;
            end
        end
        ReadData = 1'b0;
        InstrReq = 1'b0;
        chk("t3_pulses",  16'(n_pulse), 16'd6);
        chk("t3_order",   seq,          16'h0002);
        chk("t3_datain",  DataIn,       16'h00AB);
        step(2);

        // Reset during WAIT abandons the access
        ReadData = 1'b1;
        DataAddr = 16'h0030;
        step(2);
        Resetn = 1'b0;
        #1;
        chk("t5_datain",  DataIn,   16'h0000);
        chk("t5_instrin", InstrIn,  16'h0000);
        chk("t5_memaddr", MemAddr,  16'h0000);
        chk("t5_wdata",   MemWData, 16'h0000);
        chk("t5_ctl",     {12'h0, DataDone, InstrValid, MemEn, MemWe}, 16'h0000);
        ReadData = 1'b0;
        step(2);
        Resetn = 1'b1;
        n_dd = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (DataDone) n_dd++;
        end
        chk("t5_no_done",     16'(n_dd), 16'd0);
        chk("t5_late_ignore", DataIn,    16'h0000);
        ReadData = 1'b1;
        DataAddr = 16'h0020;
        step(1);
        chk("t5_re_memen", {15'h0, MemEn}, 16'h0001);
        step(3);
        chk("t5_re_done", {15'h0, DataDone}, 16'h0001);
        chk("t5_re_data", DataIn,            16'h1234);
        ReadData = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares one single-port, fixed-latency memory between the pipelined processor's instruction-fetch port and its data (Memory1/Memory2) port. It accepts requests from both ports, grants one at a time, drives a one-cycle memory command, waits out the memory latency, and returns the result with a one-cycle done pulse. The block sits between the processor top level and the unified RAM. Data accesses have priority, and a streak limit keeps instruction fetch from starving.

## Interface
Parameters:
- WORD_SIZE, 16, data and address width
- MEM_LATENCY, 2, cycles from memory command to read data valid; must be ≥ 1
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending; must be ≥ 1

Ports:
- Clock  in  1  sole clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- DataAddr  in  WORD_SIZE  data access address
- DataOut  in  WORD_SIZE  store data from the processor
- ReadData  in  1  data read request
- WriteData  in  1  data write request
- DataIn  out  WORD_SIZE  load result, registered
- DataDone  out  1  one-cycle pulse: data access complete
- InstrAddr  in  WORD_SIZE  fetch address
- InstrReq  in  1  fetch request
- InstrIn  out  WORD_SIZE  fetched word, registered
- InstrValid  out  1  one-cycle pulse: fetch complete
- MemAddr  out  WORD_SIZE  memory address
- MemWData  out  WORD_SIZE  memory write data
- MemEn  out  1  memory command strobe, exactly one cycle per access
- MemWe  out  1  write qualifier, meaningful only while MemEn=1
- MemRData  in  WORD_SIZE  memory read data, valid MEM_LATENCY cycles after the MemEn cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE.** Requests are sampled only in this state.
  - No request: stay in IDLE.
  - Otherwise latch the owner (DATA or INSTR), the address and the write data, then go to ISSUE.
- **Grant rule.**
  - Data wins if ReadData or WriteData is set, unless the streak counter equals MAX_DATA_STREAK while InstrReq=1.
  - When that condition holds, INSTR wins.
- **Streak counter.**
  - Increments on a data grant made while InstrReq=1.
  - Clears on an INSTR grant.
  - Clears on a data grant made with InstrReq=0.
  - Saturates at MAX_DATA_STREAK.
- **ReadData and WriteData both set.** Treated as a write; the read is dropped and DataIn is not updated.
- **ISSUE.**
  - Drive MemEn=1 for one cycle. MemWe=1 only for a data write.
  - MemAddr and MemWData hold the latched values.
  - Load the wait counter with MEM_LATENCY, then go to WAIT.
- **WAIT.**
  - The counter decrements each cycle; the FSM stays in WAIT for exactly MEM_LATENCY cycles.
  - On the last WAIT cycle, capture MemRData:
    - DATA read: into DataIn.
    - INSTR fetch: into InstrIn.
    - Write: nothing is captured.
  - Then go to DONE.
- **DONE.**
  - Pulse DataDone or InstrValid, according to the owner, for one cycle.
  - Requests are not sampled in this cycle, so a request still held while the done pulse is seen cannot double-issue.
  - Next state is IDLE.
- **Requester rule.** A requester holds its request and its address/data stable until it sees its done pulse, and may drop the request in the following cycle. The arbiter latches address and data in IDLE, so later changes have no effect on the access in flight.
- **Output hold.** DataIn and InstrIn hold their value until the next completed read on the same port.
- **Outside ISSUE.** MemEn=0, MemWe=0, and MemAddr/MemWData hold their last value.
- **Reset.**
  - Resetn low forces state IDLE, streak counter 0, wait counter 0.
  - All outputs go to 0: DataIn, InstrIn, DataDone, InstrValid, MemAddr, MemWData, MemEn, MemWe.
  - A reset mid-access abandons the access. No done pulse is produced and the late MemRData is ignored.

## Timing
- Request seen in IDLE at cycle t:
  - ISSUE at t+1
  - WAIT from t+2 to t+1+MEM_LATENCY
  - DONE pulse at t+2+MEM_LATENCY
- Reads and writes have the same latency.
- Back-to-back accesses: the earliest next grant is the IDLE cycle at t+3+MEM_LATENCY, so throughput is one access per MEM_LATENCY+3 cycles.
- All outputs are registered; there is no combinational path from request inputs to Mem* outputs.
- Exception: DataDone and InstrValid are decoded from the state register.

## Structure
- Shared package mem_arb_pkg holds:
  - ArbState enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE}
  - ArbOwner enum {OWN_DATA, OWN_INSTR}
  - the latched-request struct {owner, addr, wdata, we}
- Sub-module arb_grant_picker contains the streak counter and the grant decision. Inputs are the requests and an arbitrate strobe (asserted in IDLE); outputs are grant_valid and owner.
- The top level holds the FSM, the wait counter and the capture registers.

## Test plan
1. MEM_LATENCY=2. ReadData=1 with DataAddr=0x0010 and memory word 0x00AB at t=0 → MemEn=1 at cycle 1 with MemWe=0, DataDone at cycle 4, DataIn=0x00AB; InstrIn unchanged.
2. WriteData=1, DataAddr=0x0020, DataOut=0x1234 → MemEn=MemWe=1 at cycle 1, MemAddr=0x0020, MemWData=0x1234, DataDone at cycle 4; a readback from 0x0020 returns 0x1234.
3. ReadData and InstrReq held continuously with MAX_DATA_STREAK=4 → four DataDone pulses, then one InstrValid, then data again; InstrReq is never denied more than 4 consecutive grants.
4. Requester holds InstrReq through the InstrValid cycle and drops it one cycle later → exactly one MemEn for that fetch.
5. Resetn driven low during WAIT of a read → all outputs 0 immediately, no DataDone afterward; after release, a new read completes normally with the correct value.
6. ReadData=WriteData=1 → a write is performed (MemWe=1) and DataIn retains its previous value.
